// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single cache-line memory port between the instruction cache and
// the data cache. One whole transaction (read fill or writeback) is granted at
// a time. When both caches request in the same IDLE cycle, the requester that
// did not win last time is granted. The winner's command is latched so the
// memory side stays stable for the whole transaction. The memory response is
// routed back to the granted cache only.
//
// Parameters
//   ADDR_WIDTH : byte address width on all ports
//   LINE_WIDTH : cache-line data width
//   CNT_WIDTH  : width of the per-requester grant counters
//
// Ports
//   clk                : single clock, all state changes on its rising edge
//   rst                : asynchronous, active-low reset
//   i_addr/i_read/i_write/i_wdata : I-cache request side
//   i_rdata/i_resp     : I-cache fill data and completion strobe
//   d_addr/d_read/d_write/d_wdata : D-cache request side
//   d_rdata/d_resp     : D-cache fill data and completion strobe
//   mem_addr/mem_read/mem_write/mem_wdata : latched command to memory
//   mem_rdata/mem_resp : memory read data and completion strobe
//   i_grants/d_grants  : wrapping count of transactions granted to each side
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,

  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,

  output logic [CNT_WIDTH-1:0]  i_grants,
  output logic [CNT_WIDTH-1:0]  d_grants
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  state_t state;
  state_t state_next;
  side_t  owner;
  side_t  last;
  side_t  winner;

  logic i_req;
  logic d_req;
  logic grant;
  logic resp_accept;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0] sel_wdata;
  logic                  sel_read;
  logic                  sel_write;

  // A cache is requesting when either command bit is set.
  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // Fill data goes to both caches unconditionally; only the resp strobe
  // tells a cache that the data belongs to it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // State register: FSM state plus the owner of the current transaction and
  // the most recent winner. last resets to D so the first tie goes to I.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= SIDE_I;
      last  <= SIDE_D;
    end else begin
      state <= state_next;
      if (grant) begin
        owner <= winner;
        last  <= winner;
      end
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a cache that
  // still holds its request during its resp cycle cannot be re-granted
  // without passing through IDLE first. A response seen in IDLE is stray and
  // is ignored.
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    resp_accept = 1'b0;
    winner      = SIDE_I;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant      = 1'b1;
          state_next = BUSY;
          if (i_req && d_req) begin
            winner = (last == SIDE_I) ? SIDE_D : SIDE_I;
          end else if (d_req) begin
            winner = SIDE_D;
          end else begin
            winner = SIDE_I;
          end
        end
      end
      BUSY: begin
        if (mem_resp) begin
          resp_accept = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: the completion strobe is combinational from mem_resp and
  // only ever reaches the cache that owns the transaction.
  always_comb begin
    i_resp = 1'b0;
    d_resp = 1'b0;
    if ((state == BUSY) && mem_resp) begin
      if (owner == SIDE_I) begin
        i_resp = 1'b1;
      end else begin
        d_resp = 1'b1;
      end
    end
  end

  // Winner's command as it will be latched. A simultaneous read and write is
  // treated as a write, so the read bit is masked off.
  assign sel_addr  = (winner == SIDE_D) ? d_addr  : i_addr;
  assign sel_wdata = (winner == SIDE_D) ? d_wdata : i_wdata;
  assign sel_write = (winner == SIDE_D) ? d_write : i_write;
  assign sel_read  = ((winner == SIDE_D) ? d_read : i_read) & ~sel_write;

  // Memory command registers. Address and data stay latched after the
  // transaction ends; only the command bits are cleared on the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else if (grant) begin
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
      mem_read  <= sel_read;
      mem_write <= sel_write;
    end else if (resp_accept) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  // Grant counters, counted at grant time and free to wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_grants <= '0;
      d_grants <= '0;
    end else if (grant) begin
      if (winner == SIDE_I) begin
        i_grants <= i_grants + CNT_WIDTH'(1);
      end else begin
        d_grants <= d_grants + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. Requests are recorded per side when they
// are issued; a transaction-level model of the arbitration rules orders them
// into an expected queue, and a monitor on the falling edge pops and compares
// whatever the DUT presents on the memory port and the resp strobes. A small
// memory responder answers with random latency and occasional stray
// responses. The DUT uses a 4-bit counter width so wrap-around is reachable.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic          i_read, i_write, d_read, d_write;
  logic [LW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_resp, d_resp;
  logic          mem_read, mem_write, mem_resp;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] i_grants, d_grants;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .i_grants(i_grants), .d_grants(d_grants)
  );

  typedef struct {
    logic          side;
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t pend_i[$];
  txn_t pend_d[$];
  txn_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic          m_busy;
  logic          m_owner;
  logic          m_last;
  logic [CW-1:0] m_cnt_i;
  logic [CW-1:0] m_cnt_d;

  bit mem_auto = 1'b1;
  bit stray_en = 1'b0;

  task automatic checkOutput(input string name, input logic [LW-1:0] act,
                             input logic [LW-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drive a request and record what the cache asked for. Read+write counts
  // as a write with the read bit dropped.
  task automatic drive_req(input logic side, input logic [AW-1:0] addr,
                           input logic rd, input logic wr, input logic [LW-1:0] wdata);
    txn_t t;
    t.side = side; t.addr = addr; t.rd = rd & ~wr; t.wr = wr; t.wdata = wdata;
    if (!side) begin
      i_addr = addr; i_read = rd; i_write = wr; i_wdata = wdata;
      pend_i.push_back(t);
    end else begin
      d_addr = addr; d_read = rd; d_write = wr; d_wdata = wdata;
      pend_d.push_back(t);
    end
  endtask

  task automatic drop_req(input logic side);
    if (!side) begin i_read = 1'b0; i_write = 1'b0; end
    else begin d_read = 1'b0; d_write = 1'b0; end
  endtask

  // One cache transaction: hold the request until resp, optionally scramble
  // the address/data once granted, then drop the request the cycle after.
  // Called and returns just after a rising edge.
  task automatic issue(input logic side, input logic [AW-1:0] addr, input logic rd,
                       input logic wr, input logic [LW-1:0] wdata, input bit scramble);
    bit got;
    got = 1'b0;
    drive_req(side, addr, rd, wr, wdata);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((!side && i_resp) || (side && d_resp)) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (scramble) begin
        if (!side && pend_i.size() == 0) begin i_addr = addr ^ 32'h100; i_wdata = ~wdata; end
        if (side && pend_d.size() == 0) begin d_addr = addr ^ 32'h100; d_wdata = ~wdata; end
      end
    end
    checkOutput(side ? "d_resp_seen" : "i_resp_seen", LW'(got), LW'(1'b1));
    @(posedge clk); #1;
    drop_req(side);
  endtask

  task automatic applyStimulus(input logic side, input int n);
    int c;
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      c = $urandom_range(0, 2);
      issue(side, $urandom & 32'hFFFF_FFE0, c != 1, c != 0, rand_line(),
            1'($urandom_range(0, 1)));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Transaction-level model: in an idle cycle pick a winner from who is
  // requesting (tie -> not the previous winner) and queue that side's
  // recorded request; a response while busy completes the transaction.
  initial begin : model
    txn_t t;
    logic ir, dr, win;
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_cnt_i = '0; m_cnt_d = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_cnt_i = '0; m_cnt_d = '0;
        exp_q.delete(); pend_i.delete(); pend_d.delete();
      end else if (m_busy) begin
        if (mem_resp) m_busy = 1'b0;
      end else begin
        ir = i_read | i_write;
        dr = d_read | d_write;
        if (ir || dr) begin
          win = (ir && dr) ? ~m_last : dr;
          t.side = win; t.addr = '0; t.rd = 1'b0; t.wr = 1'b0; t.wdata = '0;
          if (!win && pend_i.size() > 0) t = pend_i.pop_front();
          else if (win && pend_d.size() > 0) t = pend_d.pop_front();
          else begin
            n_checks++;
            $display("[TB] FAIL model_request: side %0d requesting with nothing recorded", win);
          end
          exp_q.push_back(t);
          m_busy = 1'b1; m_owner = win; m_last = win;
          if (win) m_cnt_d++; else m_cnt_i++;
        end
      end
    end
  end

  // Monitor: compare the memory port against the expected transaction every
  // busy cycle, and the resp strobes, fill data and counters whenever any
  // response activity is visible.
  txn_t cur;
  bit   cur_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      cur_valid = 1'b0;
    end else begin
      checkOutput("busy", LW'(mem_read | mem_write), LW'(m_busy));
      if (m_busy) begin
        if (!cur_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL exp_empty: got command, expected nothing queued at %0t", $time);
          end else begin
            cur = exp_q.pop_front();
            cur_valid = 1'b1;
          end
        end
        if (cur_valid) begin
          checkOutput("mem_addr", LW'(mem_addr), LW'(cur.addr));
          checkOutput("mem_read", LW'(mem_read), LW'(cur.rd));
          checkOutput("mem_write", LW'(mem_write), LW'(cur.wr));
          checkOutput("mem_wdata", mem_wdata, cur.wdata);
        end
      end
      if (mem_resp || i_resp || d_resp) begin
        checkOutput("i_resp", LW'(i_resp), LW'(m_busy && mem_resp && !m_owner));
        checkOutput("d_resp", LW'(d_resp), LW'(m_busy && mem_resp && m_owner));
        checkOutput("i_grants", LW'(i_grants), LW'(m_cnt_i));
        checkOutput("d_grants", LW'(d_grants), LW'(m_cnt_d));
        if (i_resp) checkOutput("i_rdata", i_rdata, mem_rdata);
        if (d_resp) checkOutput("d_rdata", d_rdata, mem_rdata);
      end
      if (m_busy && mem_resp) cur_valid = 1'b0;
    end
  end

  // Memory responder: 0..3 cycles of latency after a command appears, plus
  // optional stray responses while the arbiter is idle.
  initial begin : memory
    int  wait_cnt;
    bit  armed;
    wait_cnt = 0; armed = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_auto) begin
        mem_resp  = 1'b0;
        mem_rdata = rand_line();
        if (mem_read || mem_write) begin
          if (!armed) begin armed = 1'b1; wait_cnt = $urandom_range(0, 3); end
          if (wait_cnt == 0) begin mem_resp = 1'b1; armed = 1'b0; end
          else wait_cnt--;
        end else begin
          armed = 1'b0;
          if (stray_en && $urandom_range(0, 5) == 0) mem_resp = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    rst = 1'b0;
    i_addr = '0; i_read = 1'b0; i_write = 1'b0; i_wdata = '0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    #3;
    checkOutput("rst_mem_read", LW'(mem_read), '0);
    checkOutput("rst_mem_write", LW'(mem_write), '0);
    checkOutput("rst_mem_addr", LW'(mem_addr), '0);
    checkOutput("rst_mem_wdata", mem_wdata, '0);
    checkOutput("rst_i_resp", LW'(i_resp), '0);
    checkOutput("rst_d_resp", LW'(d_resp), '0);
    checkOutput("rst_i_grants", LW'(i_grants), '0);
    checkOutput("rst_d_grants", LW'(d_grants), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single I read");
    issue(1'b0, 32'h0000_1040, 1'b1, 1'b0, rand_line(), 1'b0);
    checkOutput("single_i_grants", LW'(i_grants), LW'(1));
    checkOutput("single_d_grants", LW'(d_grants), LW'(0));

    $display("[TB] ties from reset");
    do_reset();
    fork
      issue(1'b0, 32'h0000_2000, 1'b1, 1'b0, rand_line(), 1'b0);
      issue(1'b1, 32'h0000_2100, 1'b1, 1'b0, rand_line(), 1'b0);
    join
    fork
      issue(1'b0, 32'h0000_2200, 1'b1, 1'b0, rand_line(), 1'b0);
      issue(1'b1, 32'h0000_2300, 1'b1, 1'b0, rand_line(), 1'b0);
    join

    $display("[TB] D writeback with waiting I, address changed while busy");
    fork
      begin
        issue(1'b1, 32'h0000_0200, 1'b0, 1'b1, {32{8'hA5}}, 1'b1);
        issue(1'b1, 32'h0000_0200, 1'b1, 1'b0, rand_line(), 1'b0);
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        issue(1'b0, 32'h0000_1080, 1'b1, 1'b0, rand_line(), 1'b0);
      end
    join

    $display("[TB] random traffic with stray responses");
    stray_en = 1'b1;
    fork
      applyStimulus(1'b0, 40);
      applyStimulus(1'b1, 40);
    join
    stray_en = 1'b0;
    @(posedge clk); #1;

    $display("[TB] async reset mid-transaction");
    mem_auto = 1'b0;
    mem_resp = 1'b0;
    drive_req(1'b0, 32'h0000_3000, 1'b1, 1'b0, rand_line());
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    drop_req(1'b0);
    #1;
    checkOutput("arst_mem_read", LW'(mem_read), '0);
    checkOutput("arst_mem_addr", LW'(mem_addr), '0);
    checkOutput("arst_i_grants", LW'(i_grants), '0);
    checkOutput("arst_d_grants", LW'(d_grants), '0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b1;
    @(negedge clk);
    checkOutput("late_resp_i", LW'(i_resp), '0);
    checkOutput("late_resp_d", LW'(d_resp), '0);
    @(posedge clk); #1;
    mem_resp = 1'b0;
    checkOutput("late_resp_idle", LW'(mem_read | mem_write), '0);
    checkOutput("late_resp_cnt", LW'(i_grants), '0);
    mem_auto = 1'b1;
    issue(1'b0, 32'h0000_3040, 1'b1, 1'b0, rand_line(), 1'b0);
    checkOutput("post_reset_grant", LW'(i_grants), LW'(1));

    $display("[TB] counter wrap");
    for (int j = 0; j < 16; j++) begin
      issue(1'b0, 32'h0000_4000 + 32'(j * 32), 1'b1, 1'b0, rand_line(), 1'b0);
    end
    checkOutput("wrap_i_grants", LW'(i_grants), LW'(1));
    checkOutput("wrap_d_grants", LW'(d_grants), LW'(0));
    checkOutput("final_i_model", LW'(i_grants), LW'(m_cnt_i));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single cache-line memory port between the instruction cache and the data cache. Each cache's downward-facing port (dfp) connects to one requester side. The arbiter grants one whole transaction (read fill or writeback) at a time, using round-robin on ties. It latches the winner's command so the memory side stays stable, and routes the response back to the granted cache only. It sits between the two cache instances and the burst/memory adapter.

## Interface
- `ADDR_WIDTH`, 32, byte address width on all ports.
- `LINE_WIDTH`, 256, cache-line data width.
- `CNT_WIDTH`, 32, width of per-requester grant counters.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset (block held in reset while 0).
- `i_addr` in ADDR_WIDTH: I-cache line address.
- `i_read` in 1: I-cache read request.
- `i_write` in 1: I-cache write request.
- `i_wdata` in LINE_WIDTH: I-cache writeback data.
- `i_rdata` out LINE_WIDTH: fill data to the I-cache.
- `i_resp` out 1: I-cache transaction complete.
- `d_addr`, `d_read`, `d_write`, `d_wdata`, `d_rdata`, `d_resp`: same set of signals for the D-cache.
- `mem_addr` out ADDR_WIDTH: latched address to memory.
- `mem_read` out 1: memory read command.
- `mem_write` out 1: memory write command.
- `mem_wdata` out LINE_WIDTH: latched write data.
- `mem_rdata` in LINE_WIDTH: memory read data.
- `mem_resp` in 1: memory transaction complete.
- `i_grants` out CNT_WIDTH: count of transactions granted to the I side.
- `d_grants` out CNT_WIDTH: count of transactions granted to the D side.

## Operation
- **State machine:** two states, IDLE and BUSY.
  - Register `owner` ∈ {I, D}.
  - Register `last` ∈ {I, D} holds the most recent winner.
- **Request:** a requester is requesting when its read or write is 1. If both read and write are 1, the request is a write (the latched read bit is 0).
- **IDLE, no request:** stay in IDLE.
- **IDLE, exactly one requester:** grant that requester.
- **IDLE, both requesting:** grant the requester that is not `last`.
- **On grant:**
  - Latch the winner's addr, wdata and read/write into the mem_* registers.
  - Set `owner` to the winner and `last` to the winner.
  - Increment the winner's grant counter.
  - Go to BUSY.
- **BUSY:**
  - mem_read/mem_write hold the latched command.
  - Requester inputs are ignored; changes to them mid-transaction have no effect.
- **Response in BUSY:** on mem_resp=1, assert `<owner>_resp` for that same cycle (combinational), clear mem_read and mem_write, and go to IDLE.
- **Read data:** i_rdata and d_rdata are both driven continuously from mem_rdata. Only the resp strobe qualifies the data.
- **Stray response:** mem_resp in IDLE is ignored — neither resp is asserted and no state changes.
- **Non-owner:** never receives resp.
- **Counters:** wrap modulo 2^CNT_WIDTH. There is no saturation.
- **Reset values:** state=IDLE, owner=I, last=D (so the first tie goes to I). mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, i_resp=0, d_resp=0, counters=0.
- **Reset mid-transaction:** asynchronously return to reset values immediately. The outstanding memory transaction is abandoned, and a later mem_resp arriving in IDLE is ignored.

## Timing
- **Grant latency:** a request sampled at edge t (IDLE) gives mem_read/mem_write = 1 from edge t onward, i.e. during cycle t+1. That is 1 cycle from request to memory command.
- **Response latency:** 0 cycles from mem_resp to `<owner>_resp`.
- **Return to IDLE:** BUSY→IDLE occurs at the edge ending the mem_resp cycle. There is at least one IDLE cycle between transactions, so minimum spacing is 2 cycles plus memory latency.
- **Requester rules:**
  - Each cache holds its request until its resp.
  - Each cache drops the request the cycle after resp.
  - A cache still asserting in its resp cycle is not re-granted, because sampling happens only in IDLE.
- **D writeback→allocate:** when the I side is also waiting, the round-robin rule grants I before the D fill.
- **Back-to-back:** one requester alone can be granted in every IDLE cycle with no penalty.

## Test plan
- **Single I read:** i_addr=0x0000_1040, i_read=1, memory responds 3 cycles after mem_read. Required: mem_read=1 with mem_addr=0x0000_1040 the cycle after request; i_resp=1 in the same cycle as mem_resp with i_rdata=mem_rdata; d_resp=0 throughout; i_grants=1.
- **Tie from reset:** i_read and d_read both asserted in the same cycle. Required: I granted first; D granted in the IDLE cycle after I's resp. A second tie then goes to I (last=D), alternating.
- **D writeback with waiting I:** D asserts d_write, data 0xA5 repeated, addr 0x200. I asserts i_read while D is BUSY. On D's resp, D asserts d_read. Required: mem_write with mem_wdata=0xA5…A5 first, then the I read, then the D read.
- **Input change in BUSY:** change d_addr from 0x200 to 0x300 mid-transaction. Required: mem_addr stays 0x200 until resp.
- **Stray mem_resp in IDLE:** assert mem_resp with no transaction active. Required: i_resp=d_resp=0, state stays IDLE, counters unchanged.
- **Async reset mid-BUSY:** rst=0 between edges. Required: mem_read=0 and counters=0 immediately. A mem_resp after release produces no resp; the next request is granted normally.
- **Counter wrap:** with CNT_WIDTH=4, issue 17 I grants. Required: i_grants=1.
